seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_pkg.sv | 40 ++++
 rtl/seg_scan_ctrl_if.sv | 24 ++
 rtl/seg_scan_ctrl_hex7seg.sv | 38 +++
 rtl/seg_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl_pkg
// Purpose  : Shared definitions for the 4-digit seven-segment scan controller:
//            scan FSM encoding, register addresses, CTRL bit positions and a
//            small anode-decode helper.
// Ports    : n/a (package)
// Revision : 1.0 - initial release
// ============================================================================
package seg_scan_ctrl_pkg;

  // Scan FSM encoding
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_t;

  // CPU bus geometry
  localparam int BUS_W      = 32;
  localparam int DATA_W     = 16;
  localparam int CTRL_W     = 9;
  localparam int NUM_DIGITS = 4;

  // Register addresses
  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  // CTRL register layout
  localparam int CTRL_MASK_LSB = 0;  // [3:0] digit enable mask
  localparam int CTRL_DP_LSB   = 4;  // [7:4] per-digit decimal point
  localparam int CTRL_EN_BIT   = 8;  // [8]   global scan enable

  // Active-low anode pattern selecting a single digit
  function automatic logic [NUM_DIGITS-1:0] digit_anode(input logic [1:0] digit);
    digit_anode = ~(4'b0001 << digit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl_if
// Purpose  : CPU register-access bus of the scan controller.
// Signals  : wr_en   - one-cycle write strobe
//            addr    - register select (0 = DATA, 1 = CTRL)
//            wr_data - write data, unused bits ignored by the slave
//            rd_data - combinational readback of the pending register
// Modports : master (CPU side), slave (controller side)
// Revision : 1.0 - initial release
// ============================================================================
interface seg_scan_ctrl_if;
  import seg_scan_ctrl_pkg::*;

  logic             wr_en;
  logic             addr;
  logic [BUS_W-1:0] wr_data;
  logic [BUS_W-1:0] rd_data;

  modport master (output wr_en, output addr, output wr_data, input  rd_data);
  modport slave  (input  wr_en, input  addr, input  wr_data, output rd_data);

endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl_hex7seg.sv
`default_nettype none
// ============================================================================
// Module   : hex7seg
// Purpose  : Combinational hex nibble to seven-segment glyph decoder.
// Ports    : i_hex [3:0] - nibble to display
//            o_seg [6:0] - active-low segments, bit0 = a ... bit6 = g
// Revision : 1.0 - initial release
// ============================================================================
module hex7seg (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    case (i_hex)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Time-multiplexed 4-digit seven-segment scan controller with
//            double-buffered DATA/CTRL registers and anti-ghosting blanking.
// Ports    : System_clk - sole clock, rising edge
//            reset      - asynchronous active-low reset
//            bus        - CPU register bus (slave modport)
//            ano[3:0]   - active-low digit anodes (registered)
//            BCDs[7:0]  - active-low segments, bit7 = dp (registered)
//            frame_done - one-cycle pulse as digit 3's blank slot ends
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic          System_clk,
  input  logic          reset,
  seg_scan_ctrl_if.slave bus,
  output logic [3:0]    ano,
  output logic [7:0]    BCDs,
  output logic          frame_done
);

  localparam int c_cnt_w = $clog2(DIGIT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_show_last  = c_cnt_w'(DIGIT_CYCLES - BLANK_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYCLES - 1);

  // Pending (CPU-visible) and active (displayed) register copies
  logic [DATA_W-1:0] r_pend_data, r_act_data;
  logic [CTRL_W-1:0] r_pend_ctrl, r_act_ctrl;

  // Scan state
  scan_state_t        r_state, w_state_nxt;
  logic [1:0]         r_digit, w_digit_nxt;
  logic [c_cnt_w-1:0] r_cnt,   w_cnt_nxt;

  // Output pipeline
  logic [3:0] r_ano,  w_ano_nxt;
  logic [7:0] r_bcds, w_bcds_nxt;

  logic [3:0] w_nibble;
  logic [6:0] w_seg;
  logic [3:0] w_mask, w_dp;
  logic       w_act_en;
  logic       w_frame_end;
  logic       w_unused_wr_data;

  assign w_unused_wr_data = ^bus.wr_data[BUS_W-1:DATA_W];

  assign w_mask   = r_act_ctrl[CTRL_MASK_LSB +: NUM_DIGITS];
  assign w_dp     = r_act_ctrl[CTRL_DP_LSB +: NUM_DIGITS];
  assign w_act_en = r_act_ctrl[CTRL_EN_BIT];

  // Last cycle of digit 3's blank slot: the only point where the active copy
  // may change while scanning, so a frame is never shown half-updated.
  assign w_frame_end = (r_state == ST_BLANK) && (r_digit == 2'd3) && (r_cnt == c_blank_last);
  assign frame_done  = w_frame_end;

  assign bus.rd_data = (bus.addr == ADDR_DATA) ? {{(BUS_W-DATA_W){1'b0}}, r_pend_data}
                                               : {{(BUS_W-CTRL_W){1'b0}}, r_pend_ctrl};

  // ---------------------------------------------------------------------------
  // Register file: pending written by CPU, active reloaded at frame end or
  // continuously while scanning is disabled. A write landing on the frame-end
  // cycle is seen by the active copy only at the following frame.
  // ---------------------------------------------------------------------------
  always_ff @(posedge System_clk or negedge reset) begin
    if (!reset) begin
      r_pend_data <= '0;
      r_pend_ctrl <= '0;
      r_act_data  <= '0;
      r_act_ctrl  <= '0;
    end else begin
      if (bus.wr_en) begin
        if (bus.addr == ADDR_DATA) r_pend_data <= bus.wr_data[DATA_W-1:0];
        else                       r_pend_ctrl <= bus.wr_data[CTRL_W-1:0];
      end
      if (!w_act_en || w_frame_end) begin
        r_act_data <= r_pend_data;
        r_act_ctrl <= r_pend_ctrl;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge System_clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_OFF;
      r_digit <= 2'd0;
      r_cnt   <= '0;
      r_ano   <= 4'hF;
      r_bcds  <= 8'hFF;
    end else begin
      r_state <= w_state_nxt;
      r_digit <= w_digit_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ano   <= w_ano_nxt;
      r_bcds  <= w_bcds_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM: next state and next outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_digit_nxt = r_digit;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_ano_nxt   = 4'hF;
    w_bcds_nxt  = 8'hFF;

    case (r_state)
      ST_OFF: begin
        w_cnt_nxt   = '0;
        w_digit_nxt = 2'd0;
        if (w_act_en) w_state_nxt = ST_SHOW;
      end
      ST_SHOW: begin
        if (r_cnt == c_show_last) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
        end
      end
      ST_BLANK: begin
        if (r_cnt == c_blank_last) begin
          w_cnt_nxt = '0;
          if (r_digit == 2'd3) begin
            // The active copy takes the pending value on this very edge, so
            // the pending enable decides whether another frame follows.
            w_digit_nxt = 2'd0;
            w_state_nxt = r_pend_ctrl[CTRL_EN_BIT] ? ST_SHOW : ST_OFF;
          end else begin
            w_digit_nxt = r_digit + 2'd1;
            w_state_nxt = ST_SHOW;
          end
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
        w_digit_nxt = 2'd0;
        w_cnt_nxt   = '0;
      end
    endcase

    // A masked digit keeps its slot but stays fully dark (anode and segments).
    if ((r_state == ST_SHOW) && w_mask[r_digit]) begin
      w_ano_nxt  = digit_anode(r_digit);
      w_bcds_nxt = {~w_dp[r_digit], w_seg};
    end
  end

  assign w_nibble = r_act_data[{r_digit, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .i_hex (w_nibble),
    .o_seg (w_seg)
  );

  assign ano  = r_ano;
  assign BCDs = r_bcds;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Self-checking bench for seg_scan_ctrl (DIGIT_CYCLES=8,
//            BLANK_CYCLES=2). Expected output runs (value + length) are
//            queued by the stimulus; a monitor pops and compares them each
//            time the display outputs change. A second monitor checks
//            frame_done spacing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;
  import seg_scan_ctrl_pkg::*;

  localparam int FRAME = 32;

  logic       System_clk = 1'b0;
  logic       reset      = 1'b1;
  logic [3:0] ano;
  logic [7:0] BCDs;
  logic       frame_done;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(
    .DIGIT_CYCLES (8),
    .BLANK_CYCLES (2)
  ) dut (
    .System_clk (System_clk),
    .reset      (reset),
    .bus        (bus),
    .ano        (ano),
    .BCDs       (BCDs),
    .frame_done (frame_done)
  );

  always #5 System_clk = ~System_clk;

  // --------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // --------------------------------------------------------------------------
  typedef struct {
    logic [3:0]  ano;
    logic [7:0]  bcds;
    int unsigned len;   // 0 = length not checked
  } run_t;

  run_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_run(input logic [3:0] a, input logic [7:0] b, input int unsigned n);
    run_t r;
    r.ano  = a;
    r.bcds = b;
    r.len  = n;
    exp_q.push_back(r);
  endtask

  // Full unmasked frame; the trailing blank is optional because a frame that
  // ends in OFF never produces a terminating change.
  task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3,
                            input bit last_blank);
    push_run(4'hE, s0, 6); push_run(4'hF, 8'hFF, 2);
    push_run(4'hD, s1, 6); push_run(4'hF, 8'hFF, 2);
    push_run(4'hB, s2, 6); push_run(4'hF, 8'hFF, 2);
    push_run(4'h7, s3, 6);
    if (last_blank) push_run(4'hF, 8'hFF, 2);
  endtask

  // --------------------------------------------------------------------------
  // Output-run monitor
  // --------------------------------------------------------------------------
  bit          mon_en  = 1'b0;
  logic [11:0] cur_val = '0;
  int unsigned cur_len = 0;

  always @(negedge System_clk) begin
    if (!mon_en) begin
      cur_val = {ano, BCDs};
      cur_len = 1;
    end else if ({ano, BCDs} !== cur_val) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_run: got ano=%0h BCDs=%0h len=%0d with nothing expected",
                 cur_val[11:8], cur_val[7:0], cur_len);
      end else begin
        run_t e;
        e = exp_q.pop_front();
        check("run_value", {20'd0, cur_val}, {20'd0, e.ano, e.bcds});
        if (e.len != 0) check("run_length", cur_len, e.len);
      end
      cur_val = {ano, BCDs};
      cur_len = 1;
    end else begin
      cur_len++;
    end
  end

  // --------------------------------------------------------------------------
  // frame_done monitor
  // --------------------------------------------------------------------------
  int unsigned cyc      = 0;
  int unsigned fd_count = 0;
  int unsigned fd_last  = 0;
  bit          fd_prev  = 1'b0;

  always @(negedge System_clk) begin
    cyc++;
    if (frame_done === 1'b1) begin
      fd_count++;
      if (fd_prev) check("frame_spacing", cyc - fd_last, FRAME);
      fd_last = cyc;
      fd_prev = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic bus_write(input logic a, input logic [31:0] d);
    @(posedge System_clk); #1;
    bus.wr_en   = 1'b1;
    bus.addr    = a;
    bus.wr_data = d;
    @(posedge System_clk); #1;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
  endtask

  task automatic wait_fd(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge System_clk);
      n++;
    end while (frame_done !== 1'b1 && n < budget);
    check(name, {31'd0, frame_done}, 32'd1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge System_clk); #1;
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int unsigned fd_base;
    bit          bad;

    bus.wr_en   = 1'b0;
    bus.addr    = ADDR_DATA;
    bus.wr_data = '0;
    #1 reset = 1'b0;
    repeat (3) @(posedge System_clk);
    #1;
    check("reset_ano",        ano,        4'hF);
    check("reset_bcds",       BCDs,       8'hFF);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_rd_data",    bus.rd_data, 32'h0);
    bus.addr = ADDR_CTRL; #1;
    check("reset_rd_ctrl",    bus.rd_data, 32'h0);
    @(negedge System_clk);
    reset = 1'b1;

    // ---- Phase B: normal scan, buffered updates, masking ----
    push_run(4'hF, 8'hFF, 0);
    push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b1);   // F1: 1234
    push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b1);   // F2: still 1234
    push_frame(8'h8E, 8'h8E, 8'h8E, 8'h8E, 1'b1);   // F3: FFFF
    push_run(4'hE, 8'h0E, 6); push_run(4'hF, 8'hFF, 10);   // F4: mask 0101, dp on
    push_run(4'hB, 8'h0E, 6); push_run(4'hF, 8'hFF, 10);
    push_run(4'hE, 8'h0E, 6); push_run(4'hF, 8'hFF, 10);   // F5 up to digit 2
    mon_en  = 1'b1;
    fd_prev = 1'b0;

    bus_write(ADDR_DATA, 32'hABCD_1234);
    check("rd_data_data", bus.rd_data, 32'h0000_1234);
    bus_write(ADDR_CTRL, 32'hFFFF_F10F);
    check("rd_data_ctrl", bus.rd_data, 32'h0000_010F);

    wait_fd("fd1_seen", 100);
    repeat (10) @(posedge System_clk);
    bus_write(ADDR_DATA, 32'h0000_FFFF);             // mid-frame data update

    wait_fd("fd2_seen", 64);
    bus.wr_en   = 1'b1;                              // write on the frame_done cycle
    bus.addr    = ADDR_CTRL;
    bus.wr_data = 32'h0000_01F5;
    @(posedge System_clk); #1;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    check("rd_data_ctrl_fd", bus.rd_data, 32'h0000_01F5);

    wait_drain("queue_drained_b", 300);
    check("pre_reset_ano", ano, 4'hB);
    mon_en = 1'b0;
    #1;
    reset = 1'b0;                                    // asynchronous, mid-cycle
    #1;
    check("async_reset_ano",  ano,  4'hF);
    check("async_reset_bcds", BCDs, 8'hFF);
    check("async_reset_fd",   frame_done, 1'b0);
    bus.addr = ADDR_DATA; #1;
    check("post_reset_rd_data", bus.rd_data, 32'h0);
    bus.addr = ADDR_CTRL; #1;
    check("post_reset_rd_ctrl", bus.rd_data, 32'h0);
    fd_prev = 1'b0;
    repeat (2) @(posedge System_clk);
    #3 reset = 1'b1;

    fd_base = fd_count;
    bad = 1'b0;
    repeat (60) begin
      @(negedge System_clk);
      if (ano !== 4'hF || BCDs !== 8'hFF || frame_done !== 1'b0) bad = 1'b1;
    end
    check("idle_after_reset", {31'd0, bad}, 32'd0);
    check("idle_no_frames", fd_count - fd_base, 0);

    // ---- Phase C: three frames, then disable ----
    push_run(4'hF, 8'hFF, 0);
    push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b1);
    push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b1);
    push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b1);
    push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b0);
    mon_en  = 1'b1;
    fd_base = fd_count;
    bus_write(ADDR_CTRL, 32'h0000_010F);
    begin
      int n = 0;
      while (fd_count < fd_base + 3 && n < 200) begin
        @(negedge System_clk); #1;
        n++;
      end
    end
    check("three_frames", fd_count - fd_base, 3);
    bus_write(ADDR_CTRL, 32'h0);
    repeat (40) @(negedge System_clk);
    #1;
    check("last_frame_completed", fd_count - fd_base, 4);
    check("queue_drained_c", exp_q.size(), 0);
    bad = 1'b0;
    repeat (60) begin
      @(negedge System_clk);
      if (ano !== 4'hF || frame_done !== 1'b0) bad = 1'b1;
    end
    check("off_after_disable", {31'd0, bad}, 32'd0);
    check("no_extra_frames", fd_count - fd_base, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got time %0t required < 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
